// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types, flag indices and format constants for fp_mul_pipe
package fp_mul_pkg;
  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RDN, RM_RUP} rm_e;
  localparam int FLAG_INX = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_INV = 3;
  typedef struct packed {
    logic is_zero;
    logic is_sub;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } cls_t;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan(input int ew, input int fw);
    return (((64'd1 << ew) - 64'd1) << fw) | (64'd1 << (fw - 1));
  endfunction
  function automatic logic [63:0] max_fin(input int ew, input int fw);
    return (((64'd1 << ew) - 64'd2) << fw) | ((64'd1 << fw) - 64'd1);
  endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter; all-zero input returns W
module fp_lzc #(
  parameter int W = 22,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val,
  output logic [CW-1:0] cnt
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) cnt = val[i] ? CW'(W - 1 - i) : cnt;
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 4-stage parametrised FP multiplier with valid/ready; FP_MUL_FTZ_EN flushes subnormals to zero
module fp_mul_pipe import fp_mul_pkg::*; #(
  parameter int EXP_W = 5,
  parameter int FRAC_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  input  logic [1:0]              in_rm,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_res,
  output logic [TAG_W-1:0]        out_tag,
  output logic [3:0]              out_flags
);
  localparam int W = EXP_W + FRAC_W + 1;
  localparam int M = FRAC_W + 1;
  localparam int P = 2 * M;
  localparam int LW = $clog2(P + 1);
  localparam int SW = EXP_W + LW + 2;
  localparam int BIAS = bias(EXP_W);
  localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, FRAC_W));
  localparam logic [W-1:0] MAXF = W'(max_fin(EXP_W, FRAC_W));
  localparam logic [EXP_W-1:0] EMAX = '1;
  function automatic cls_t classify(input logic [W-1:0] x);
    cls_t c;
    c.is_inf = &x[W-2:FRAC_W] & ~|x[FRAC_W-1:0];
    c.is_nan = &x[W-2:FRAC_W] & |x[FRAC_W-1:0];
    c.is_snan = c.is_nan & ~x[FRAC_W-1];
    c.is_sub = ~|x[W-2:FRAC_W] & |x[FRAC_W-1:0];
`ifdef FP_MUL_FTZ_EN
    c.is_zero = ~|x[W-2:FRAC_W];
`else
    c.is_zero = ~|x[W-2:0];
`endif
    return c;
  endfunction
  logic adv;
  logic v1, v2, v3;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  cls_t ca, cb;
  logic sign, nan, zinf, inf, spec;
  logic [W-1:0] sres;
  logic [3:0] sflg;
  always_comb begin
    ca = classify(in_a);
    cb = classify(in_b);
    sign = in_a[W-1] ^ in_b[W-1];
    nan = ca.is_nan | cb.is_nan;
    zinf = (ca.is_zero & cb.is_inf) | (ca.is_inf & cb.is_zero);
    inf = ca.is_inf | cb.is_inf;
    spec = nan | inf | ca.is_zero | cb.is_zero;
    sres = nan | zinf ? QNAN : inf ? {sign, EMAX, {FRAC_W{1'b0}}} : {sign, {(W-1){1'b0}}};
    sflg = '0;
    sflg[FLAG_INV] = zinf | ca.is_snan | cb.is_snan;
`ifdef FP_MUL_FTZ_EN
    sflg[FLAG_UNF] = ~(nan | inf) & (ca.is_sub | cb.is_sub);
    sflg[FLAG_INX] = ~(nan | inf) & (ca.is_sub | cb.is_sub);
`endif
  end
  logic s1_sign, s1_spec;
  logic [M-1:0] s1_ma, s1_mb;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [W-1:0] s1_sres;
  logic [3:0] s1_sflg;
  rm_e s1_rm;
  logic [TAG_W-1:0] s1_tag;
  logic s2_sign, s2_spec;
  logic [P-1:0] s2_prod;
  logic [EXP_W+1:0] s2_esum;
  logic [W-1:0] s2_sres;
  logic [3:0] s2_sflg;
  rm_e s2_rm;
  logic [TAG_W-1:0] s2_tag;
  logic [LW-1:0] lz;
  logic [SW-1:0] e;
  logic [P-1:0] nm, sig;
  logic tiny, stk;
`ifdef FP_MUL_FTZ_EN
  always_comb begin
    lz = LW'(~s2_prod[P-1]);
    nm = s2_prod << lz;
    e = {{(SW-EXP_W-2){s2_esum[EXP_W+1]}}, s2_esum} - SW'(lz);
    tiny = e[SW-1] | ~|e;
    sig = nm;
    stk = 1'b0;
  end
`else
  logic [SW-1:0] sh;
  logic far;
  fp_lzc #(.W(P), .CW(LW)) u_lzc (.val(s2_prod), .cnt(lz));
  // tiny results shift right into the subnormal range; anything past guard folds into sticky
  always_comb begin
    nm = s2_prod << lz;
    e = {{(SW-EXP_W-2){s2_esum[EXP_W+1]}}, s2_esum} - SW'(lz);
    tiny = e[SW-1] | ~|e;
    sh = SW'(1) - e;
    far = sh > SW'(M + 1);
    sig = ~tiny ? nm : far ? '0 : nm >> sh;
    stk = tiny & (far | |(nm & ~({P{1'b1}} << sh)));
  end
`endif
  logic s3_sign, s3_spec, s3_tiny, s3_stk;
  logic [P-1:0] s3_sig;
  logic [SW-1:0] s3_e;
  logic [W-1:0] s3_sres;
  logic [3:0] s3_sflg;
  rm_e s3_rm;
  logic [TAG_W-1:0] s3_tag;
  logic [M-1:0] mant;
  logic [M:0] mr;
  logic [SW-1:0] ef;
  logic g, st, up, ovf, sat;
  logic [W-1:0] res;
  logic [3:0] flg;
  always_comb begin
    mant = s3_sig[P-1 -: M];
    g = s3_sig[M-1];
    st = |s3_sig[M-2:0] | s3_stk;
    up = s3_rm == RM_RNE ? g & (st | mant[0]) :
         s3_rm == RM_RDN ? s3_sign & (g | st) :
         s3_rm == RM_RUP ? ~s3_sign & (g | st) : 1'b0;
    mr = {1'b0, mant} + (M+1)'(up);
    ef = s3_tiny ? SW'(mr[M-1]) : s3_e + SW'(mr[M]);
    ovf = ~s3_tiny & (ef >= SW'(2**EXP_W - 1));
    sat = s3_rm == RM_RTZ | (s3_rm == RM_RDN & ~s3_sign) | (s3_rm == RM_RUP & s3_sign);
    res = ovf ? (sat ? {s3_sign, MAXF[W-2:0]} : {s3_sign, EMAX, {FRAC_W{1'b0}}}) :
          {s3_sign, ef[EXP_W-1:0], mr[FRAC_W-1:0]};
    flg = '0;
    flg[FLAG_OVF] = ovf;
    flg[FLAG_UNF] = s3_tiny & (g | st);
    flg[FLAG_INX] = g | st | ovf;
`ifdef FP_MUL_FTZ_EN
    res = s3_tiny ? {s3_sign, {(W-1){1'b0}}} : res;
    flg[FLAG_UNF] = flg[FLAG_UNF] | s3_tiny;
    flg[FLAG_INX] = flg[FLAG_INX] | s3_tiny;
`endif
    res = s3_spec ? s3_sres : res;
    flg = s3_spec ? s3_sflg : flg;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_valid <= 1'b0;
      out_res <= '0;
      out_tag <= '0;
      out_flags <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      out_valid <= v3;
      if (v3) begin
        out_res <= res;
        out_tag <= s3_tag;
        out_flags <= flg;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign <= sign;
      s1_spec <= spec;
      s1_ma <= {|in_a[W-2:FRAC_W], in_a[FRAC_W-1:0]};
      s1_mb <= {|in_b[W-2:FRAC_W], in_b[FRAC_W-1:0]};
      s1_ea <= in_a[W-2:FRAC_W] | EXP_W'(~|in_a[W-2:FRAC_W]);
      s1_eb <= in_b[W-2:FRAC_W] | EXP_W'(~|in_b[W-2:FRAC_W]);
      s1_sres <= sres;
      s1_sflg <= sflg;
      s1_rm <= rm_e'(in_rm);
      s1_tag <= in_tag;
      s2_sign <= s1_sign;
      s2_spec <= s1_spec;
      s2_prod <= s1_ma * s1_mb;
      s2_esum <= (EXP_W+2)'(s1_ea) + (EXP_W+2)'(s1_eb) - (EXP_W+2)'(BIAS - 1);
      s2_sres <= s1_sres;
      s2_sflg <= s1_sflg;
      s2_rm <= s1_rm;
      s2_tag <= s1_tag;
      s3_sign <= s2_sign;
      s3_spec <= s2_spec;
      s3_tiny <= tiny;
      s3_stk <= stk;
      s3_sig <= sig;
      s3_e <= e;
      s3_sres <= s2_sres;
      s3_sflg <= s2_sflg;
      s3_rm <= s2_rm;
      s3_tag <= s2_tag;
    end
  end
endmodule
